display_page_arbiter: RTL and testbench

- Shares the single 8-digit seven-segment display between NUM_SRC requesters, e.g. order count, P&L, latency stats and error codes.
- Rotates pages round-robin with a programmable dwell time.
- Lets urgent sources pre-empt the rotation and supports a freeze hold.
- Sits directly upstream of display_8hex; data_out drives its 32-bit data_in.

---
 rtl/display_page_arbiter.sv | 144 ++++++++++++++
 tb/tb_display_page_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_page_arbiter.sv
// Round-robin page arbiter sharing one 8-digit display between NUM_SRC sources.
// Optional macro DISPLAY_PAGE_TAG_EN shows the page index in the leftmost digit.
module display_page_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int SEL_W        = $clog2(NUM_SRC),
  parameter int CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [NUM_SRC-1:0]    src_valid_in,
  input  logic [NUM_SRC*32-1:0] src_data_in,
  input  logic [NUM_SRC-1:0]    urgent_in,
  input  logic                  freeze_in,
  output logic [31:0]           data_out,
  output logic [SEL_W-1:0]      page_out,
  output logic                  blank_out,
  output logic [NUM_SRC-1:0]    ack_out,
  output logic                  dwell_done_out
);

  // Handshake: src_valid_in[i] is a level meaning "source i has data"; there is
  // no ready. ack_out[i] pulses for one cycle on the edge source i is granted.
  typedef enum logic [1:0] {IDLE, SELECT, SHOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t             state_q;
  logic [31:0]        data_q;
  logic [SEL_W-1:0]   page_q;
  logic               blank_q;
  logic [NUM_SRC-1:0] ack_q;
  logic               dwell_done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               granted_q;

  logic [31:0]        src_arr [NUM_SRC];
  logic [NUM_SRC-1:0] urg_vld;
  logic [SEL_W-1:0]   start_idx;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   win_idx;
  logic               win_found;
  logic [31:0]        cur_disp;
  logic [31:0]        win_disp;
  logic               expired;
  logic               lost;
  logic               preempt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_arr[g] = src_data_in[32*g +: 32];
  end

  assign urg_vld = urgent_in & src_valid_in;

  // Until the first grant the search starts at source 0 so rotation begins at page 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    start_idx = granted_q ? SEL_W'((int'(page_q) + 1) % NUM_SRC) : '0;
    if (|urg_vld) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (urg_vld[i] && !win_found) begin
          win_found = 1'b1;
          win_idx   = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = SEL_W'((int'(start_idx) + k) % NUM_SRC);
        if (src_valid_in[idx] && !win_found) begin
          win_found = 1'b1;
          win_idx   = idx;
        end
      end
    end
  end

  always_comb begin
`ifdef DISPLAY_PAGE_TAG_EN
    cur_disp = {4'(page_q), src_arr[page_q][27:0]};
    win_disp = {4'(win_idx), src_arr[win_idx][27:0]};
`else
    cur_disp = src_arr[page_q];
    win_disp = src_arr[win_idx];
`endif
    expired = (cnt_q == CNT_LAST) && !freeze_in;
    lost    = !src_valid_in[page_q];
    preempt = (|urg_vld) && !urg_vld[page_q];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      data_q       <= '0;
      page_q       <= '0;
      blank_q      <= 1'b1;
      ack_q        <= '0;
      dwell_done_q <= 1'b0;
      cnt_q        <= '0;
      granted_q    <= 1'b0;
    end else begin
      ack_q        <= '0;
      dwell_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          data_q  <= '0;
          blank_q <= 1'b1;
          if (|src_valid_in) state_q <= SELECT;
        end
        SELECT: begin
          if (win_found) begin
            page_q    <= win_idx;
            data_q    <= win_disp;
            blank_q   <= 1'b0;
            ack_q     <= NUM_SRC'(1) << win_idx;
            cnt_q     <= '0;
            granted_q <= 1'b1;
            state_q   <= SHOW;
          end else begin
            data_q  <= '0;
            blank_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        SHOW: begin
          data_q <= cur_disp;
          if (expired) dwell_done_q <= 1'b1;
          // The counter parks on its terminal value while waiting to leave SHOW.
          if (expired || lost || preempt) state_q <= SELECT;
          else if (!freeze_in)            cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = data_q;
  assign page_out       = page_q;
  assign blank_out      = blank_q;
  assign ack_out        = ack_q;
  assign dwell_done_out = dwell_done_q;

endmodule

// File: tb/tb_display_page_arbiter.sv
// Self-checking bench for display_page_arbiter: behavioural page model compared
// every cycle, plus directed literal checks of rotation, urgency, freeze and reset.
module tb_display_page_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic [N-1:0]  src_valid_in = '0;
  logic [N*32-1:0] src_data_in;
  logic [N-1:0]  urgent_in = '0;
  logic          freeze_in = 1'b0;
  logic [31:0]   data_out;
  logic [1:0]    page_out;
  logic          blank_out;
  logic [N-1:0]  ack_out;
  logic          dwell_done_out;

  logic [31:0]   src [N];

  int n_total  = 0;
  int n_passed = 0;

  display_page_arbiter #(.NUM_SRC(N), .DWELL_CYCLES(DW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .src_valid_in(src_valid_in),
    .src_data_in(src_data_in), .urgent_in(urgent_in), .freeze_in(freeze_in),
    .data_out(data_out), .page_out(page_out), .blank_out(blank_out),
    .ack_out(ack_out), .dwell_done_out(dwell_done_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  always_comb begin
    for (int i = 0; i < N; i++) src_data_in[32*i +: 32] = src[i];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_passed++;
  endtask

  function automatic logic [31:0] disp(input int page, input logic [31:0] d);
`ifdef DISPLAY_PAGE_TAG_EN
    disp = {4'(page), d[27:0]};
`else
    disp = d;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // Phases: waiting for any source, choosing a page, or showing a page.
  localparam int PH_WAIT = 0, PH_PICK = 1, PH_SHOW = 2;
  int          m_phase;
  int          m_page;
  int          m_shown;     // unfrozen cycles spent on the current page
  bit          m_ever;      // some page has been granted since reset
  logic [31:0] m_data;
  logic        m_blank;
  logic [N-1:0] m_ack;
  logic        m_dd;

  function automatic int pick_page(input logic [N-1:0] v, input logic [N-1:0] u,
                                   input int last, input bit ever);
    int cand[$];
    int first;
    first = ever ? (last + 1) % N : 0;
    if ((u & v) != '0) begin
      for (int i = 0; i < N; i++) if (u[i] && v[i]) cand.push_back(i);
    end else begin
      for (int k = 0; k < N; k++) if (v[(first + k) % N]) cand.push_back((first + k) % N);
    end
    pick_page = (cand.size() > 0) ? cand[0] : -1;
  endfunction

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_phase = PH_WAIT; m_page = 0; m_shown = 0; m_ever = 0;
      m_data = '0; m_blank = 1'b1; m_ack = '0; m_dd = 1'b0;
    end else begin
      bit timeout, gone, bumped;
      int w;
      m_ack = '0;
      m_dd  = 1'b0;
      if (m_phase == PH_WAIT) begin
        m_data = '0; m_blank = 1'b1;
        if (src_valid_in != '0) m_phase = PH_PICK;
      end else if (m_phase == PH_PICK) begin
        w = pick_page(src_valid_in, urgent_in, m_page, m_ever);
        if (w < 0) begin
          m_phase = PH_WAIT; m_data = '0; m_blank = 1'b1;
        end else begin
          m_page = w; m_ever = 1; m_shown = 0; m_blank = 1'b0;
          m_data = disp(w, src[w]); m_ack = N'(1) << w; m_phase = PH_SHOW;
        end
      end else begin
        m_data  = disp(m_page, src[m_page]);
        timeout = (m_shown >= DW - 1) && !freeze_in;
        gone    = !src_valid_in[m_page];
        bumped  = ((urgent_in & src_valid_in) != '0) && !(urgent_in[m_page] && src_valid_in[m_page]);
        if (timeout) m_dd = 1'b1;
        if (timeout || gone || bumped) m_phase = PH_PICK;
        else if (!freeze_in) m_shown++;
      end
    end
  end

  // One compare process, on the falling edge away from the active edge.
  always @(negedge clk_in) begin
    chk("data_out", data_out, m_data);
    chk("page_out", 32'(page_out), 32'(m_page));
    chk("blank_out", 32'(blank_out), 32'(m_blank));
    chk("ack_out", 32'(ack_out), 32'(m_ack));
    chk("dwell_done_out", 32'(dwell_done_out), 32'(m_dd));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_ack(input logic [N-1:0] want, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (ack_out == want) ok = 1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic set_all_data();
    for (int i = 0; i < N; i++) src[i] = 32'h1111_1111 * (i + 1);
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] exp_q[$];
  logic [N-1:0] ack_v[$];
  int           ack_c[$];
  int           dd_c[$];

  initial begin
    set_all_data();
    tick(); tick();
    chk("reset data_out", data_out, 32'h0);
    chk("reset page_out", 32'(page_out), 32'h0);
    chk("reset blank_out", 32'(blank_out), 32'h1);
    chk("reset ack_out", 32'(ack_out), 32'h0);
    chk("reset dwell_done", 32'(dwell_done_out), 32'h0);

    // Rotation with all sources valid.
    src_valid_in = 4'b1111;
    rst_n_in = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (ack_out != '0) begin
        ack_v.push_back(ack_out);
        ack_c.push_back(c);
        if (ack_v.size() == 1) chk("first grant data", data_out, disp(0, 32'h1111_1111));
      end
      if (dwell_done_out) dd_c.push_back(c);
    end
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("ack count", 32'(ack_v.size()), 32'd5);
    chk("first ack cycle", 32'(ack_c.size() > 0 ? ack_c[0] : -1), 32'd2);
    for (int k = 0; k < 5 && k < ack_v.size(); k++) begin
      chk("ack sequence", 32'(ack_v[k]), 32'(exp_q[k]));
      if (k > 0) chk("ack spacing", 32'(ack_c[k] - ack_c[k-1]), 32'd5);
      if (k > 0 && k - 1 < dd_c.size()) chk("dwell before regrant", 32'(dd_c[k-1]), 32'(ack_c[k] - 1));
    end

    // Only source 2 valid, then drop it.
    src_valid_in = 4'b0100;
    wait_ack(4'b0100, 20, "wait src2 grant");
    wait_ack(4'b0100, 6, "src2 regrant");
    chk("src2 page held", 32'(page_out), 32'd2);
    tick(); tick();
    src_valid_in = 4'b0000;
    tick(); tick();
    chk("idle blank", 32'(blank_out), 32'd1);
    chk("idle data", data_out, 32'h0);

    // Urgent pre-emption of src 0 at counter 1.
    src_valid_in = 4'b1111;
    wait_ack(4'b0001, 30, "wait src0 grant");
    tick();
    urgent_in = 4'b1000;
    tick(); tick();
    chk("urgent page", 32'(page_out), 32'd3);
    chk("urgent ack", 32'(ack_out), 32'b1000);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("urgent page held", 32'(page_out), 32'd3);
    end
    urgent_in = '0;

    // Freeze while showing src 1, live data update, urgent through freeze.
    wait_ack(4'b0010, 40, "wait src1 grant");
    freeze_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("freeze page", 32'(page_out), 32'd1);
      chk("freeze no dwell", 32'(dwell_done_out), 32'd0);
    end
    src[1] = 32'hDEAD_BEEF;
    tick();
    chk("live data", data_out, disp(1, 32'hDEAD_BEEF));
    urgent_in = 4'b0001;
    tick(); tick();
    chk("urgent in freeze page", 32'(page_out), 32'd0);
    chk("urgent in freeze ack", 32'(ack_out), 32'b0001);
    freeze_in = 1'b0;
    urgent_in = '0;
    set_all_data();

    // Wrap from page 3 to page 1 with valid 1010.
    src_valid_in = 4'b1010;
    wait_ack(4'b1000, 20, "wait src3 grant");
    wait_ack(4'b0010, 10, "wrap to src1");
    chk("wrap page", 32'(page_out), 32'd1);

    // Asynchronous reset mid-SHOW, checked before any clock edge.
    tick();
    rst_n_in = 1'b0;
    #1;
    chk("async data_out", data_out, 32'h0);
    chk("async page_out", 32'(page_out), 32'h0);
    chk("async blank_out", 32'(blank_out), 32'h1);
    chk("async ack_out", 32'(ack_out), 32'h0);
    tick();
    rst_n_in = 1'b1;

`ifdef DISPLAY_PAGE_TAG_EN
    src_valid_in = 4'b0100;
    src[2] = 32'hFFFF_FFFF;
    wait_ack(4'b0100, 20, "wait tag grant");
    chk("tag data", data_out, 32'h2FFF_FFFF);
    set_all_data();
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0)  src_valid_in = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && src_valid_in == '0) src_valid_in = N'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0)
        urgent_in = ($urandom_range(0, 1) == 0) ? '0 : N'(1) << $urandom_range(0, N - 1);
      if ($urandom_range(0, 11) == 0) freeze_in = ~freeze_in;
      src[$urandom_range(0, N - 1)] = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
